// File: rtl/dino_game_sequencer.sv
// Per-frame dino game controller: jump physics, obstacle scroll/respawn, scoring and
// the IDLE/RUN/OVER game flow, all advanced once per screen_ready rising edge.
module dino_game_sequencer #(
    parameter int DINO_X        = 240,
    parameter int GROUND_Y      = 320,
    parameter int JUMP_HEIGHT   = 120,
    parameter int JUMP_STEP     = 6,
    parameter int OBST_START_X  = 680,
    parameter int OBST_SPEED    = 4,
    parameter int MAX_SPEED     = 12,
    parameter int SPEEDUP_EVERY = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        screen_ready,
    input  logic        collision_detected,
    input  logic        start_btn,
    input  logic        jump_btn,
    output logic [31:0] x_coor,
    output logic [31:0] y_coor,
    output logic [31:0] x_coor_obstacle,
    output logic [31:0] y_coor_obstacle,
    output logic [15:0] score,
    output logic        game_over,
    output logic [1:0]  game_state
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_OVER = 2'b10;

    localparam logic [1:0] J_GROUND = 2'b00;
    localparam logic [1:0] J_RISE   = 2'b01;
    localparam logic [1:0] J_FALL   = 2'b10;

    localparam logic [11:0] GROUND_C = 12'(GROUND_Y);
    localparam logic [11:0] APEX_C   = 12'(GROUND_Y - JUMP_HEIGHT);
    localparam logic [11:0] STEP_C   = 12'(JUMP_STEP);
    localparam logic [11:0] START_C  = 12'(OBST_START_X);
    localparam logic [11:0] SPEED0_C = 12'(OBST_SPEED);
    localparam logic [11:0] MAXSPD_C = 12'(MAX_SPEED);
    localparam logic [7:0]  EVERY_C  = 8'(SPEEDUP_EVERY);

    logic [1:0]  state_r;
    logic [1:0]  jump_r;
    logic [11:0] dino_y_r;
    logic [11:0] obst_x_r;
    logic [11:0] speed_r;
    logic [7:0]  respawn_cnt_r;
    logic [15:0] score_r;
    logic        game_over_r;
    logic        screen_ready_q_r;

    logic        tick_s;
    logic        run_tick_s;
    logic        reload_s;
    logic [1:0]  jump_nxt_s;
    logic [11:0] dino_y_nxt_s;
    logic [11:0] obst_x_nxt_s;
    logic [11:0] speed_nxt_s;
    logic [7:0]  respawn_cnt_nxt_s;
    logic [15:0] score_nxt_s;

    // Frame tick and game-flow qualifiers.
    always_comb begin
        tick_s     = screen_ready & ~screen_ready_q_r;
        run_tick_s = tick_s & (state_r == ST_RUN);
        reload_s   = start_btn & (state_r != ST_RUN);
    end

    // Next-frame dino and obstacle values, applied only on a collision-free RUN tick.
    always_comb begin
        jump_nxt_s        = jump_r;
        dino_y_nxt_s      = dino_y_r;
        obst_x_nxt_s      = obst_x_r;
        speed_nxt_s       = speed_r;
        respawn_cnt_nxt_s = respawn_cnt_r;
        score_nxt_s       = score_r;
        case (jump_r)
            J_GROUND: begin
                if (jump_btn) begin
                    dino_y_nxt_s = dino_y_r - STEP_C;
                    jump_nxt_s   = J_RISE;
                end else begin
                    dino_y_nxt_s = dino_y_r;
                end
            end
            J_RISE: begin
                if (dino_y_r <= APEX_C + STEP_C) begin
                    dino_y_nxt_s = APEX_C;
                    jump_nxt_s   = J_FALL;
                end else begin
                    dino_y_nxt_s = dino_y_r - STEP_C;
                end
            end
            J_FALL: begin
                if (dino_y_r + STEP_C >= GROUND_C) begin
                    dino_y_nxt_s = GROUND_C;
                    jump_nxt_s   = J_GROUND;
                end else begin
                    dino_y_nxt_s = dino_y_r + STEP_C;
                end
            end
            default: begin
                dino_y_nxt_s = GROUND_C;
                jump_nxt_s   = J_GROUND;
            end
        endcase
        // Wrap instead of subtracting when the step would underflow.
        if (obst_x_r >= speed_r) begin
            obst_x_nxt_s = obst_x_r - speed_r;
        end else begin
            obst_x_nxt_s = START_C;
            score_nxt_s  = (score_r == 16'hFFFF) ? score_r : score_r + 16'd1;
            if (respawn_cnt_r + 8'd1 >= EVERY_C) begin
                respawn_cnt_nxt_s = 8'd0;
                speed_nxt_s       = (speed_r >= MAXSPD_C) ? MAXSPD_C : speed_r + 12'd1;
            end else begin
                respawn_cnt_nxt_s = respawn_cnt_r + 8'd1;
            end
        end
    end

    // Game state, positions and score; collision on a tick wins over any movement.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r          <= ST_IDLE;
            jump_r           <= J_GROUND;
            dino_y_r         <= GROUND_C;
            obst_x_r         <= START_C;
            speed_r          <= SPEED0_C;
            respawn_cnt_r    <= 8'd0;
            score_r          <= 16'd0;
            game_over_r      <= 1'b0;
            screen_ready_q_r <= 1'b0;
        end else begin
            screen_ready_q_r <= screen_ready;
            if (reload_s) begin
                state_r       <= ST_RUN;
                jump_r        <= J_GROUND;
                dino_y_r      <= GROUND_C;
                obst_x_r      <= START_C;
                speed_r       <= SPEED0_C;
                respawn_cnt_r <= 8'd0;
                score_r       <= 16'd0;
                game_over_r   <= 1'b0;
            end else if (run_tick_s && collision_detected) begin
                state_r     <= ST_OVER;
                game_over_r <= 1'b1;
            end else if (run_tick_s) begin
                jump_r        <= jump_nxt_s;
                dino_y_r      <= dino_y_nxt_s;
                obst_x_r      <= obst_x_nxt_s;
                speed_r       <= speed_nxt_s;
                respawn_cnt_r <= respawn_cnt_nxt_s;
                score_r       <= score_nxt_s;
            end else if (state_r == 2'b11) begin
                state_r     <= ST_IDLE;
                game_over_r <= 1'b0;
            end
        end
    end

    assign x_coor          = 32'(DINO_X);
    assign y_coor          = {20'd0, dino_y_r};
    assign x_coor_obstacle = {20'd0, obst_x_r};
    assign y_coor_obstacle = 32'(GROUND_Y);
    assign score           = score_r;
    assign game_over       = game_over_r;
    assign game_state      = state_r;

endmodule
